// File: rtl/log2_if.sv
// Request/result bundle for the iterative base-2 logarithm unit.
// The master side issues start/din; the slave side returns busy/done/err and the result.
interface log2_if #(
  parameter int DIN_W  = 41,
  parameter int FRAC_W = 8
);
  logic              start;
  logic [DIN_W-1:0]  din;
  logic              busy;
  logic              done;
  logic              err;
  logic [5:0]        int_part;
  logic [FRAC_W-1:0] frac_part;

  modport master (
    output start, din,
    input  busy, done, err, int_part, frac_part
  );

  modport slave (
    input  start, din,
    output busy, done, err, int_part, frac_part
  );
endinterface

// File: rtl/log2_calc.sv
// Iterative fixed-point log2: leading-one normalise, then one squaring step per fractional bit.
// Optional macro LOG2_ROUND_EN computes one guard bit and rounds half up with saturation.
module log2_calc #(
  parameter int DIN_W  = 41,
  parameter int FRAC_W = 8,
  parameter int M_W    = 16
) (
  input  logic   clk,
  input  logic   reset,
  log2_if.slave  bus
);

`ifdef LOG2_ROUND_EN
  localparam int FRAC_BITS = FRAC_W + 1;
`else
  localparam int FRAC_BITS = FRAC_W;
`endif
  localparam int          PT_W    = M_W + 1;
  localparam logic [5:0]  CNT_TOP = 6'(DIN_W - 1);
  localparam logic [3:0]  K_LAST  = 4'(FRAC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [DIN_W-1:0]       x_r;
  logic [5:0]             cnt_r;
  logic [M_W-1:0]         m_r;
  logic [3:0]             k_r;
  logic [FRAC_BITS-1:0]   acc_r;
  logic                   busy_r, done_r, err_r;
  logic [5:0]             int_r;
  logic [FRAC_W-1:0]      frac_r;

  logic [PT_W-1:0]        p_top_s;
  logic [M_W-1:0]         m_next_s;
  logic [FRAC_BITS-1:0]   acc_s;
  logic [FRAC_W-1:0]      frac_final_s;
  logic                   din_zero_s;

`ifdef LOG2_ROUND_EN
  // Add the guard bit to the truncated fraction; all-ones stays all-ones (no carry into the integer part).
  function automatic logic [FRAC_W-1:0] round_sat(input logic [FRAC_W:0] a);
    logic [FRAC_W:0] sum;
    sum = {1'b0, a[FRAC_W:1]} + {{FRAC_W{1'b0}}, a[0]};
    if (sum[FRAC_W]) begin
      return a[FRAC_W:1];
    end else begin
      return sum[FRAC_W-1:0];
    end
  endfunction
`endif

  // Square of the 1.15 mantissa keeps only bits [31:15] of the 2.30 product.
  assign p_top_s    = PT_W'(({{M_W{1'b0}}, m_r} * {{M_W{1'b0}}, m_r}) >> (M_W - 1));
  assign din_zero_s = (bus.din == {DIN_W{1'b0}});

  // Squaring step: renormalise the product and shift the new bit into the accumulator.
  always_comb begin
    m_next_s = p_top_s[M_W-1:0];
    acc_s    = acc_r << 1;
    if (p_top_s[PT_W-1]) begin
      m_next_s = p_top_s[PT_W-1:1];
      acc_s[0] = 1'b1;
    end else begin
      m_next_s = p_top_s[M_W-1:0];
      acc_s[0] = 1'b0;
    end
`ifdef LOG2_ROUND_EN
    frac_final_s = round_sat(acc_s);
`else
    frac_final_s = acc_s;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = din_zero_s ? DONE : NORM;
        end else begin
          state_s = IDLE;
        end
      end
      NORM: begin
        if (x_r[DIN_W-1]) begin
          state_s = FRAC;
        end else begin
          state_s = NORM;
        end
      end
      FRAC: begin
        if (k_r == K_LAST) begin
          state_s = DONE;
        end else begin
          state_s = FRAC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; results hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r    <= {DIN_W{1'b0}};
      cnt_r  <= 6'd0;
      m_r    <= {M_W{1'b0}};
      k_r    <= 4'd0;
      acc_r  <= {FRAC_BITS{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      int_r  <= 6'd0;
      frac_r <= {FRAC_W{1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start && din_zero_s) begin
            err_r  <= 1'b1;
            int_r  <= 6'd0;
            frac_r <= {FRAC_W{1'b0}};
          end else if (bus.start) begin
            err_r  <= 1'b0;
            x_r    <= bus.din;
            cnt_r  <= CNT_TOP;
          end
        end
        NORM: begin
          if (x_r[DIN_W-1]) begin
            int_r <= cnt_r;
            m_r   <= x_r[DIN_W-1 -: M_W];
            k_r   <= 4'd0;
            acc_r <= {FRAC_BITS{1'b0}};
          end else begin
            x_r   <= x_r << 1;
            cnt_r <= cnt_r - 6'd1;
          end
        end
        FRAC: begin
          m_r   <= m_next_s;
          acc_r <= acc_s;
          k_r   <= k_r + 4'd1;
          if (k_r == K_LAST) begin
            frac_r <= frac_final_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.int_part  = int_r;
  assign bus.frac_part = frac_r;

endmodule

// File: tb/tb_log2_calc.sv
// Directed, table-driven bench for log2_calc plus hand sequences for reset, abort and ignored starts.
// Latencies are counted as cycles from the accepting edge to the Done cycle (accepting edge = 1).
module tb_log2_calc;
  localparam int FRAC_W = 8;
`ifdef LOG2_ROUND_EN
  localparam int         EXTRA = 1;
  localparam logic [7:0] FP3   = 8'h96;
`else
  localparam int         EXTRA = 0;
  localparam logic [7:0] FP3   = 8'h95;
`endif
  localparam int MAX_WAIT = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  log2_if #(.DIN_W(41), .FRAC_W(FRAC_W)) bus ();

  log2_calc #(.DIN_W(41), .FRAC_W(FRAC_W), .M_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [40:0] din;
    logic [5:0]  ip;
    logic [7:0]  fp;
    logic        er;
    int          n;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done from the current cycle count; returns -1 on timeout.
  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < MAX_WAIT) begin
      step();
      cyc++;
    end
    if (!bus.done) cyc = -1;
  endtask

  task automatic run_op(input logic [40:0] d, output int cyc, output logic [5:0] ip,
                        output logic [7:0] fp, output logic er, output logic busy0);
    bus.start = 1'b1;
    bus.din   = d;
    step();
    bus.start = 1'b0;
    bus.din   = ~d;
    busy0     = bus.busy;
    cyc       = 1;
    wait_done(cyc);
    ip = bus.int_part;
    fp = bus.frac_part;
    er = bus.err;
  endtask

  initial begin
    int          cyc;
    int          done_seen;
    logic [5:0]  ip;
    logic [7:0]  fp;
    logic        er;
    logic        b0;

    vecs[0] = '{41'd1,                   6'd0,  8'h00, 1'b0, 50 + EXTRA};
    vecs[1] = '{41'd5,                   6'd2,  8'h52, 1'b0, 48 + EXTRA};
    vecs[2] = '{41'h100_0000_0000,       6'd40, 8'h00, 1'b0, 10 + EXTRA};
    vecs[3] = '{41'd0,                   6'd0,  8'h00, 1'b1, 1};
    vecs[4] = '{41'd5,                   6'd2,  8'h52, 1'b0, 48 + EXTRA};
    vecs[5] = '{41'd3,                   6'd1,  FP3,   1'b0, 49 + EXTRA};
    vecs[6] = '{41'd6,                   6'd2,  FP3,   1'b0, 48 + EXTRA};
    vecs[7] = '{41'h0C0_0000_0000,       6'd39, FP3,   1'b0, 11 + EXTRA};
    vecs[8] = '{41'h000_0010_0000,       6'd20, 8'h00, 1'b0, 30 + EXTRA};

    // Reset held 10 cycles with a start request that must be ignored.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.din   = 41'd5;
    repeat (10) step();
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_err",  64'(bus.err),  64'd0);
    check("reset_int",  64'(bus.int_part),  64'd0);
    check("reset_frac", 64'(bus.frac_part), 64'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    step();
    check("idle_busy", 64'(bus.busy), 64'd0);

    // Table: each op starts the cycle after the previous Done (back-to-back).
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].din, cyc, ip, fp, er, b0);
      check($sformatf("v%0d_busy", i), 64'(b0), 64'd1);
      check($sformatf("v%0d_lat", i),  64'(cyc), 64'(vecs[i].n));
      check($sformatf("v%0d_int", i),  64'(ip),  64'(vecs[i].ip));
      check($sformatf("v%0d_frac", i), 64'(fp),  64'(vecs[i].fp));
      check($sformatf("v%0d_err", i),  64'(er),  64'(vecs[i].er));
      step();
      check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
      check($sformatf("v%0d_busy_end", i),   64'(bus.busy), 64'd0);
    end

    // Start while busy is ignored: Din=1, second start with Din=5 in cycle 20.
    bus.start = 1'b1;
    bus.din   = 41'd1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    repeat (18) begin
      step();
      cyc++;
    end
    bus.start = 1'b1;
    bus.din   = 41'd5;
    step();
    cyc++;
    bus.start = 1'b0;
    wait_done(cyc);
    check("busy_ign_lat",  64'(cyc), 64'(50 + EXTRA));
    check("busy_ign_int",  64'(bus.int_part),  64'd0);
    check("busy_ign_frac", 64'(bus.frac_part), 64'd0);

    // Start presented during the Done cycle is not accepted.
    bus.start = 1'b1;
    bus.din   = 41'd5;
    step();
    bus.start = 1'b0;
    check("done_cyc_start_busy", 64'(bus.busy), 64'd0);
    check("done_cyc_start_int",  64'(bus.int_part), 64'd0);

    // Reset in cycle 30 of a Din=1 run aborts it with no Done.
    bus.start = 1'b1;
    bus.din   = 41'd1;
    step();
    bus.start = 1'b0;
    repeat (28) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_int",  64'(bus.int_part), 64'd0);
    done_seen = 0;
    repeat (60) begin
      step();
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_op(41'd5, cyc, ip, fp, er, b0);
    check("post_abort_lat",  64'(cyc), 64'(48 + EXTRA));
    check("post_abort_int",  64'(ip), 64'd2);
    check("post_abort_frac", 64'(fp), 64'h52);
    check("post_abort_err",  64'(er), 64'd0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
